// File: rtl/cpu_debug_bridge.sv
// Boot loader and debug readout bridge for the core: assembles the byte-serial
// instruction image into imem, then offers manual or streamed byte-lane peeks.
module cpu_debug_bridge #(
    parameter  int XLEN       = 32,
    parameter  int IMEM_DEPTH = 64,
    parameter  int ADDR_W     = 11,
    parameter  int SCAN_WORDS = 21,
    localparam int LANES      = XLEN / 8,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int IMEM_AW    = $clog2(IMEM_DEPTH)
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    input  logic [7:0]         instr_i,
    input  logic               instr_valid,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    input  logic               DataOrReg,
    input  logic [ADDR_W-1:0]  address,
    input  logic [LANE_W-1:0]  vout_addr,
    output logic               dbg_sel,
    output logic [ADDR_W-1:0]  dbg_addr,
    input  logic [XLEN-1:0]    dbg_rdata,
    output logic [7:0]         value_o,
    input  logic               scan_start,
    output logic               scan_valid,
    output logic               scan_last,
    output logic               scan_busy
);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    localparam logic [LANE_W-1:0]  LANE_MAX = LANE_W'(LANES - 1);
    localparam logic [ADDR_W-1:0]  ENTRY_MAX = ADDR_W'(SCAN_WORDS - 1);
    localparam logic [IMEM_AW-1:0] LAST_WORD = IMEM_AW'(IMEM_DEPTH - 1);
    localparam logic [IMEM_AW:0]   WORD_LIM = (IMEM_AW + 1)'(IMEM_DEPTH);

    state_t              state_q, state_d;
    logic [XLEN-9:0]     word_buf;
    logic [LANE_W-1:0]   byte_cnt;
    logic [IMEM_AW:0]    word_cnt;
    logic                scan_act;
    logic                scan_sel_q;
    logic [ADDR_W-1:0]   scan_entry;
    logic [LANE_W-1:0]   scan_lane;

    logic                byte_take;
    logic                word_full;
    logic                scan_go;
    logic                lane_end;
    logic                entry_end;
    logic [LANE_W-1:0]   rd_lane;
    logic [XLEN-1:0]     next_word;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) state_q <= S_LOAD;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        byte_take = 1'b0;
        scan_go   = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                byte_take = instr_valid && (word_cnt < WORD_LIM);
                if (imem_we && imem_waddr == LAST_WORD)
                    state_d = S_RUN;
            end
            S_RUN: scan_go = scan_start && !scan_busy;
            default: ;
        endcase
    end

    assign next_word = {word_buf, instr_i};
    assign word_full = byte_take && (byte_cnt == LANE_MAX);
    assign lane_end  = (scan_lane == '0);
    assign entry_end = (scan_entry == ENTRY_MAX);

    // The scan owns the core-facing read port while it is issuing entries.
    assign dbg_sel   = scan_act ? scan_sel_q : DataOrReg;
    assign dbg_addr  = scan_act ? scan_entry : address;
    assign rd_lane   = scan_act ? scan_lane  : vout_addr;

    assign scan_busy = scan_act | scan_valid;
    assign cpu_hold  = (state_q == S_LOAD);
    assign load_done = (state_q == S_RUN);

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            word_buf   <= '0;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= word_full;
            if (byte_take) begin
                word_buf <= next_word[XLEN-9:0];
                byte_cnt <= word_full ? '0 : byte_cnt + 1'b1;
            end
            if (word_full) begin
                imem_wdata <= next_word;
                imem_waddr <= word_cnt[IMEM_AW-1:0];
                word_cnt   <= word_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            scan_act   <= 1'b0;
            scan_sel_q <= 1'b0;
            scan_entry <= '0;
            scan_lane  <= '0;
            scan_valid <= 1'b0;
            scan_last  <= 1'b0;
            value_o    <= '0;
        end else begin
            value_o    <= dbg_rdata[{rd_lane, 3'b000} +: 8];
            scan_valid <= scan_act;
            scan_last  <= scan_act && lane_end && entry_end;
            if (scan_go) begin
                scan_act   <= 1'b1;
                scan_sel_q <= DataOrReg;
                scan_entry <= '0;
                scan_lane  <= LANE_MAX;
            end else if (scan_act) begin
                if (lane_end) begin
                    scan_lane <= LANE_MAX;
                    if (entry_end) scan_act <= 1'b0;
                    else           scan_entry <= scan_entry + 1'b1;
                end else begin
                    scan_lane <= scan_lane - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_debug_bridge.sv
// Directed/randomized bench for cpu_debug_bridge with a behavioural core
// memory model and a queue-based expectation of the load and scan streams.
module tb_cpu_debug_bridge;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 11;
    localparam int SW    = 21;
    localparam int LANES = XLEN / 8;

    logic          sys_clk = 1'b0;
    logic          sys_reset = 1'b1;
    logic [7:0]    instr_i = '0;
    logic          instr_valid = 1'b0;
    logic          imem_we;
    logic [5:0]    imem_waddr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          DataOrReg = 1'b0;
    logic [AW-1:0] address = '0;
    logic [1:0]    vout_addr = '0;
    logic          dbg_sel;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_rdata;
    logic [7:0]    value_o;
    logic          scan_start = 1'b0;
    logic          scan_valid;
    logic          scan_last;
    logic          scan_busy;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    bit mon_en = 1'b0;
    bit hold_pending = 1'b0;
    logic [31:0] exp_q[$];
    logic [7:0]  scan_q[$];
    logic [31:0] regs[32];
    logic [31:0] dmem[2048];

    always #5 sys_clk = ~sys_clk;

    assign dbg_rdata = dbg_sel ? regs[dbg_addr[4:0]] : dmem[dbg_addr];

    cpu_debug_bridge dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset),
        .instr_i(instr_i), .instr_valid(instr_valid),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done),
        .DataOrReg(DataOrReg), .address(address), .vout_addr(vout_addr),
        .dbg_sel(dbg_sel), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
        .value_o(value_o), .scan_start(scan_start), .scan_valid(scan_valid),
        .scan_last(scan_last), .scan_busy(scan_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any imem write seen there.
    task automatic tick();
        logic [31:0] w;
        @(negedge sys_clk);
        if (mon_en) begin
            if (hold_pending) begin
                check("hold_release", {cpu_hold, load_done}, 2'b01);
                hold_pending = 1'b0;
            end
            if (imem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("imem_extra_we", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("imem_waddr", imem_waddr, 64'(wr_cnt));
                    check("imem_wdata", imem_wdata, w);
                end
                wr_cnt++;
                if (wr_cnt == DEPTH) begin
                    check("hold_at_last_wr", cpu_hold, 1);
                    hold_pending = 1'b1;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        while ($urandom_range(0, 3) == 0) begin
            instr_valid = 1'b0;
            scan_start  = 1'($urandom_range(0, 1));
            tick();
            check("load_scan_busy", scan_busy, 0);
        end
        instr_valid = 1'b1;
        instr_i     = b;
        scan_start  = 1'($urandom_range(0, 1));
        tick();
        instr_valid = 1'b0;
        scan_start  = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 sys_reset = 1'b1;
        #1;
        check("rst_async_outs",
              {cpu_hold, load_done, imem_we, value_o, scan_busy},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        @(negedge sys_clk);
        sys_reset = 1'b0;
    endtask

    task automatic run_scan(input logic sel);
        int n;
        logic [31:0] w;
        scan_q.delete();
        for (int e = 0; e < SW; e++) begin
            w = sel ? regs[e] : dmem[e];
            for (int l = LANES - 1; l >= 0; l--) scan_q.push_back(w[8*l +: 8]);
        end
        DataOrReg  = sel;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_busy_rise", {scan_busy, scan_valid}, 2'b10);
        n = 0;
        while (scan_valid !== 1'b1 && n < 4) begin tick(); n++; end
        check("scan_first_valid_in_time", scan_valid, 1);
        for (int i = 0; i < SW * LANES; i++) begin
            check("scan_valid", scan_valid, 1);
            check("scan_byte", value_o, scan_q[i]);
            check("scan_last", scan_last, (i == SW * LANES - 1) ? 1 : 0);
            if (i == 40) begin
                scan_start = 1'b1;
                DataOrReg  = ~sel;
                address    = AW'($urandom_range(0, 2047));
                vout_addr  = 2'($urandom_range(0, 3));
            end
            if (i == 41) scan_start = 1'b0;
            tick();
        end
        check("scan_end", {scan_valid, scan_busy, scan_last}, 3'b000);
    endtask

    initial begin
        logic [7:0] img[DEPTH*4];
        int n;
        logic [31:0] w;

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 2048; i++) dmem[i] = $urandom;
        regs[5] = 32'h12345678;
        DataOrReg = 1'b1;
        address   = 5;
        vout_addr = 0;

        repeat (2) @(negedge sys_clk);
        check("rst_outs",
              {cpu_hold, load_done, imem_we, value_o, scan_valid, scan_busy},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        sys_reset = 1'b0;
        tick();
        check("load_peek", value_o, 8'h78);

        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        pulse_reset();
        mon_en = 1'b1;
        exp_q.push_back(32'hAABBCCDD);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        tick(); tick();
        check("restart_wr_count", wr_cnt, 1);

        mon_en = 1'b0;
        pulse_reset();
        exp_q.delete();
        wr_cnt = 0;
        img[0] = 8'h00; img[1] = 8'h50; img[2] = 8'h02; img[3] = 8'h93;
        for (int i = 4; i < DEPTH * 4; i++) img[i] = 8'($urandom);
        for (int k = 0; k < DEPTH; k++)
            exp_q.push_back({img[4*k], img[4*k+1], img[4*k+2], img[4*k+3]});
        check("first_word_model", exp_q[0], 32'h00500293);
        mon_en = 1'b1;
        for (int i = 0; i < DEPTH * 4; i++) send_byte(img[i]);
        n = 0;
        while (cpu_hold === 1'b1 && n < 10) begin tick(); n++; end
        tick();
        check("load_wr_count", wr_cnt, DEPTH);
        check("load_queue_empty", exp_q.size(), 0);
        check("run_flags", {cpu_hold, load_done}, 2'b01);

        for (int i = 0; i < 8; i++) begin
            instr_valid = 1'b1;
            instr_i = 8'($urandom);
            tick();
            check("run_no_imem_we", imem_we, 0);
        end
        instr_valid = 1'b0;

        DataOrReg = 1'b1; address = 5; vout_addr = 3;
        tick();
        check("manual_lane3", value_o, 8'h12);
        vout_addr = 0;
        tick();
        check("manual_lane0", value_o, 8'h78);
        for (int i = 0; i < 16; i++) begin
            DataOrReg = 1'($urandom_range(0, 1));
            address   = AW'($urandom_range(0, 2047));
            vout_addr = 2'($urandom_range(0, 3));
            w = DataOrReg ? regs[address[4:0]] : dmem[address];
            tick();
            check("manual_rand", value_o, w[8*vout_addr +: 8]);
        end

        for (int e = 0; e < SW; e++) regs[e] = {4{8'(e)}};
        run_scan(1'b1);
        run_scan(1'b0);
        DataOrReg = 1'b0; address = 7; vout_addr = 2;
        tick();
        check("manual_after_scan", value_o, dmem[7][23:16]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
